// File: rtl/osc_mon_pkg.sv
// osc_mon_pkg: shared types, default constants and a width helper for the
// oscillator frequency monitor.
package osc_mon_pkg;

  // Measurement controller states
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } oscState_t;

  // Default window length (reference-clock cycles) and edge-count limits
  localparam int DEF_WINDOW_CYCLES = 1000;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_MIN_EDGES     = 190;
  localparam int DEF_MAX_EDGES     = 210;
  localparam int DEF_LOCK_WINDOWS  = 4;

  // Bits needed to hold a window position from 0 to cycles-1
  function automatic int winCntWidth(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // Bits needed to hold a good-window count from 0 to windows inclusive
  function automatic int goodCntWidth(input int windows);
    return (windows <= 1) ? 1 : $clog2(windows + 1);
  endfunction

endpackage

// File: rtl/osc_mon_edge_sync.sv
// osc_mon_edge_sync: brings the monitored oscillator into the reference clock
// domain through two flops, then compares against one more flop of history
// to produce a single-cycle strobe per rising edge.
module osc_mon_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // Synchronizer chain; r_sync3 is the previous synchronized sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_sync3;

endmodule

// File: rtl/osc_freq_monitor.sv
// osc_freq_monitor: counts rising edges of a slower, asynchronous oscillator
// over fixed windows of the reference clock, reports each window's count,
// flags out-of-range windows and raises LOCK after a run of good windows.
// Optional interrupt output is built when OSC_FREQ_MONITOR_IRQ_EN is defined.
module osc_freq_monitor
  import osc_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int MIN_EDGES     = DEF_MIN_EDGES,
  parameter int MAX_EDGES     = DEF_MAX_EDGES,
  parameter int LOCK_WINDOWS  = DEF_LOCK_WINDOWS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_mon_clk,
`ifdef OSC_FREQ_MONITOR_IRQ_EN
  input  logic             i_irq_clr,
  output logic             o_irq,
`endif
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_count_valid,
  output logic             o_in_range,
  output logic             o_lock,
  output logic             o_fail
);

  localparam int WIN_W  = winCntWidth(WINDOW_CYCLES);
  localparam int GOOD_W = goodCntWidth(LOCK_WINDOWS);

  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  MIN_CNT     = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]  MAX_CNT     = CNT_W'(MAX_EDGES);
  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_WINDOWS);

  oscState_t         r_state;
  oscState_t         w_nextState;

  logic              w_monEdge;
  logic              w_start;
  logic              w_countEn;
  logic              w_windowEnd;
  logic              w_abort;

  logic [WIN_W-1:0]  r_winCnt;
  logic [CNT_W-1:0]  r_edgeCnt;
  logic [CNT_W-1:0]  w_edgeFinal;
  logic              w_finalInRange;

  logic [CNT_W-1:0]  r_edgeCount;
  logic              r_countValid;
  logic              r_inRange;

  logic [GOOD_W-1:0] r_goodCnt;
  logic [GOOD_W-1:0] w_goodNext;
  logic              r_lock;
  logic              w_lockNext;
  logic              r_fail;
  logic              w_failNext;
  logic              r_everLock;

  osc_mon_edge_sync u_edge_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_mon_clk),
    .o_edge  (w_monEdge)
  );

  // Controller state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Controller next state: ENABLE alone decides between idling and measuring
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_enable)  w_nextState = MEASURE;
      MEASURE: if (!i_enable) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Controller outputs: window start, counting, window end and abort strobes
  always_comb begin
    w_start     = 1'b0;
    w_countEn   = 1'b0;
    w_abort     = 1'b0;
    w_windowEnd = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = i_enable;
      end
      MEASURE: begin
        w_countEn   = i_enable;
        w_abort     = ~i_enable;
        w_windowEnd = i_enable && (r_winCnt == WIN_LAST);
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Count including this cycle's edge, held at all-ones once saturated
  always_comb begin
    w_edgeFinal = r_edgeCnt;
    if (w_monEdge && (r_edgeCnt != CNT_SAT)) begin
      w_edgeFinal = r_edgeCnt + 1'b1;
    end
  end

  assign w_finalInRange = (w_edgeFinal >= MIN_CNT) && (w_edgeFinal <= MAX_CNT);

  // Window and edge counters; both restart on the window's last cycle so
  // consecutive windows abut with no dead cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_winCnt  <= '0;
      r_edgeCnt <= '0;
    end else if (w_start || w_abort) begin
      r_winCnt  <= '0;
      r_edgeCnt <= '0;
    end else if (w_countEn) begin
      if (w_windowEnd) begin
        r_winCnt  <= '0;
        r_edgeCnt <= '0;
      end else begin
        r_winCnt  <= r_winCnt + 1'b1;
        r_edgeCnt <= w_edgeFinal;
      end
    end
  end

  // Window result: latch the final count and range verdict, pulse valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edgeCount  <= '0;
      r_inRange    <= 1'b0;
      r_countValid <= 1'b0;
    end else begin
      r_countValid <= w_windowEnd;
      if (w_windowEnd) begin
        r_edgeCount <= w_edgeFinal;
        r_inRange   <= w_finalInRange;
      end
    end
  end

  // Lock bookkeeping: good windows build toward LOCK, a bad window clears it
  // and, once LOCK has ever been seen, latches FAIL
  always_comb begin
    w_goodNext = r_goodCnt;
    w_lockNext = r_lock;
    w_failNext = r_fail;
    if (w_abort) begin
      w_goodNext = '0;
      w_lockNext = 1'b0;
    end else if (w_windowEnd) begin
      if (w_finalInRange) begin
        if (r_goodCnt != GOOD_TARGET) begin
          w_goodNext = r_goodCnt + 1'b1;
        end
        w_lockNext = (w_goodNext == GOOD_TARGET);
      end else begin
        w_goodNext = '0;
        w_lockNext = 1'b0;
        if (r_lock || r_everLock) begin
          w_failNext = 1'b1;
        end
      end
    end
  end

  // Lock state registers; the ever-locked flag survives ENABLE drops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_goodCnt  <= '0;
      r_lock     <= 1'b0;
      r_fail     <= 1'b0;
      r_everLock <= 1'b0;
    end else begin
      r_goodCnt  <= w_goodNext;
      r_lock     <= w_lockNext;
      r_fail     <= w_failNext;
      r_everLock <= r_everLock | w_lockNext;
    end
  end

`ifdef OSC_FREQ_MONITOR_IRQ_EN
  logic w_irqSet;
  logic r_irq;

  assign w_irqSet = (w_failNext & ~r_fail) | (r_lock & ~w_lockNext);

  // Interrupt latch: a new event takes priority over a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else if (w_irqSet) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irq = r_irq;
`endif

  assign o_edge_count  = r_edgeCount;
  assign o_count_valid = r_countValid;
  assign o_in_range    = r_inRange;
  assign o_lock        = r_lock;
  assign o_fail        = r_fail;

endmodule

// File: tb/tb_osc_freq_monitor.sv
// tb_osc_freq_monitor: drives windows with a chosen number of monitored-clock
// rising edges placed well inside each window, and compares every window
// result against a window-level model of count, range, lock and fail.
module tb_osc_freq_monitor;

  localparam int W      = 1000;
  localparam int CNT_W  = 16;
  localparam int MIN_E  = 190;
  localparam int MAX_E  = 210;
  localparam int LOCK_N = 4;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             enable = 1'b0;
  logic             monClk = 1'b0;
  logic [CNT_W-1:0] edgeCount;
  logic             countValid;
  logic             inRange;
  logic             lock;
  logic             failFlag;
`ifdef OSC_FREQ_MONITOR_IRQ_EN
  logic             irqClr = 1'b0;
  logic             irq;
`endif

  osc_freq_monitor dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_enable      (enable),
    .i_mon_clk     (monClk),
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    .i_irq_clr     (irqClr),
    .o_irq         (irq),
`endif
    .o_edge_count  (edgeCount),
    .o_count_valid (countValid),
    .o_in_range    (inRange),
    .o_lock        (lock),
    .o_fail        (failFlag)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;
  int spuriousValid = 0;

  int mCount = 0;
  int mGood = 0;
  bit mInRange = 1'b0;
  bit mLock = 1'b0;
  bit mFail = 1'b0;
  bit mEverLock = 1'b0;

  // Window-level model: apply one completed window of c rising edges
  function automatic void modelWindow(input int c);
    mCount   = (c > 65535) ? 65535 : c;
    mInRange = (mCount >= MIN_E) && (mCount <= MAX_E);
    if (mInRange) begin
      if (mGood < LOCK_N) mGood++;
      mLock = (mGood == LOCK_N);
    end else begin
      if (mLock || mEverLock) mFail = 1'b1;
      mGood = 0;
      mLock = 1'b0;
    end
    if (mLock) mEverLock = 1'b1;
  endfunction

  // Drives window positions firstPos..lastPos (one per negedge).
  // mode 0: n pulses, rising edges between positions 2 and 990, ending low
  // mode 1: monClk held at its present level
  // mode 2: monClk rises at position 5 and stays high
  task automatic driveWindow(input int n, input int mode, input int firstPos, input int lastPos);
    int p, start, hi, span, off;
    logic h;
    p = 2; start = 2; hi = 1;
    if (mode == 0 && n > 0) begin
      p = (n == 1) ? 4 : 988 / (n - 1);
      if (p > 4) p = 4;
      p = $urandom_range(p, 2);
      span = 990 - (n - 1) * p;
      if (span > 30) span = 30;
      start = $urandom_range(span, 2);
      hi = $urandom_range(p - 1, 1);
    end
    for (int j = firstPos; j <= lastPos; j++) begin
      @(negedge clk);
      if (countValid === 1'b1) spuriousValid++;
      if (mode == 0) begin
        h = 1'b0;
        if (n > 0 && j >= start) begin
          off = j - start;
          if ((off / p) < n && (off % p) < hi) h = 1'b1;
        end
        monClk = h;
      end else if (mode == 2) begin
        monClk = (j >= 5);
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (edgeCount !== '0 || countValid !== 1'b0 || inRange !== 1'b0 || lock !== 1'b0 || failFlag !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got count=%0d valid=%b inRange=%b lock=%b fail=%b, want all 0", edgeCount, countValid, inRange, lock, failFlag);
    end
    rstN = 1'b1;
    spuriousValid = 0;
    repeat (20) begin
      @(negedge clk);
      if (countValid === 1'b1) spuriousValid++;
    end
    testsRun++;
    if (spuriousValid != 0 || lock !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle: got validPulses=%0d lock=%b, want 0 0", spuriousValid, lock);
    end
  endtask

  task automatic test_nominal();
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      spuriousValid = 0;
      driveWindow(200, 0, 1, W - 1);
      @(negedge clk);
      modelWindow(200);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL nominal_w%0d: got early=%0d valid=%b count=%0d inRange=%b lock=%b fail=%b, want early=0 valid=1 count=%0d inRange=%b lock=%b fail=%b", k, spuriousValid, countValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mLock, mFail);
      end
      if (k == 3) begin
        testsRun++;
        if (lock !== 1'b1) begin
          testsFailed++;
          $display("[TB] FAIL nominal_lock_4th: got lock=%b, want 1", lock);
        end
      end
    end
  endtask

  task automatic test_stuck();
    int modes[3] = '{1, 2, 1};
    int cnts[3] = '{0, 1, 0};
    monClk = 1'b0;
    for (int k = 0; k < 3; k++) begin
      spuriousValid = 0;
      driveWindow(0, modes[k], 1, W - 1);
      @(negedge clk);
      modelWindow(cnts[k]);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL stuck_w%0d: got early=%0d valid=%b count=%0d inRange=%b lock=%b fail=%b, want early=0 valid=1 count=%0d inRange=%b lock=%b fail=%b", k, spuriousValid, countValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mLock, mFail);
      end
      if (k == 0) begin
        testsRun++;
        if (failFlag !== 1'b1 || lock !== 1'b0 || edgeCount !== '0) begin
          testsFailed++;
          $display("[TB] FAIL stuck_low_fail: got fail=%b lock=%b count=%0d, want 1 0 0", failFlag, lock, edgeCount);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int cnts[8] = '{200, 195, 205, 200, 190, 210, 189, 211};
    for (int k = 0; k < 8; k++) begin
      spuriousValid = 0;
      driveWindow(cnts[k], 0, 1, W - 1);
      @(negedge clk);
      modelWindow(cnts[k]);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL boundary_%0d: got early=%0d valid=%b count=%0d inRange=%b lock=%b fail=%b, want early=0 valid=1 count=%0d inRange=%b lock=%b fail=%b", cnts[k], spuriousValid, countValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mLock, mFail);
      end
    end
  endtask

  task automatic test_random();
    int c;
    for (int k = 0; k < 6; k++) begin
      c = ($urandom_range(1, 0) == 1) ? int'($urandom_range(MAX_E, MIN_E)) : int'($urandom_range(400, 0));
      spuriousValid = 0;
      driveWindow(c, 0, 1, W - 1);
      @(negedge clk);
      modelWindow(c);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL random_%0d: got early=%0d valid=%b count=%0d inRange=%b lock=%b fail=%b, want early=0 valid=1 count=%0d inRange=%b lock=%b fail=%b", c, spuriousValid, countValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mLock, mFail);
      end
    end
  endtask

  task automatic test_enable_abort();
    int c;
    for (int k = 0; k < 5; k++) begin
      c = (k < 4) ? int'($urandom_range(MAX_E, MIN_E)) : 200;
      spuriousValid = 0;
      driveWindow(c, 0, 1, (k < 4) ? W - 1 : 499);
      if (k == 4) break;
      @(negedge clk);
      modelWindow(c);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL abort_pre_%0d: got early=%0d valid=%b count=%0d inRange=%b lock=%b fail=%b, want early=0 valid=1 count=%0d inRange=%b lock=%b fail=%b", c, spuriousValid, countValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mLock, mFail);
      end
    end
    @(negedge clk);
    enable = 1'b0;
    monClk = 1'b0;
    mLock = 1'b0;
    mGood = 0;
    spuriousValid = 0;
    repeat (600) begin
      @(negedge clk);
      if (countValid === 1'b1) spuriousValid++;
    end
    testsRun++;
    if (spuriousValid != 0 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== 1'b0 || failFlag !== mFail) begin
      testsFailed++;
      $display("[TB] FAIL abort_hold: got pulses=%0d count=%0d inRange=%b lock=%b fail=%b, want 0 %0d %b 0 %b", spuriousValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mFail);
    end
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      c = $urandom_range(MAX_E, MIN_E);
      spuriousValid = 0;
      driveWindow(c, 0, 1, W - 1);
      @(negedge clk);
      modelWindow(c);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL reenable_w%0d: got early=%0d valid=%b count=%0d inRange=%b lock=%b fail=%b, want early=0 valid=1 count=%0d inRange=%b lock=%b fail=%b", k, spuriousValid, countValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mLock, mFail);
      end
    end
  endtask

  task automatic test_async_reset();
    int cnts[5] = '{200, 200, 200, 200, 150};
    for (int k = 0; k < 4; k++) begin
      spuriousValid = 0;
      driveWindow(cnts[k], 0, 1, W - 1);
      @(negedge clk);
      modelWindow(cnts[k]);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL prereset_w%0d: got early=%0d count=%0d lock=%b fail=%b, want 0 %0d %b %b", k, spuriousValid, edgeCount, lock, failFlag, mCount, mLock, mFail);
      end
    end
    driveWindow(200, 0, 1, 300);
    #2;
    rstN = 1'b0;
    #1;
    testsRun++;
    if (edgeCount !== '0 || countValid !== 1'b0 || inRange !== 1'b0 || lock !== 1'b0 || failFlag !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got count=%0d valid=%b inRange=%b lock=%b fail=%b, want all 0", edgeCount, countValid, inRange, lock, failFlag);
    end
    @(negedge clk);
    enable = 1'b0;
    monClk = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    mCount = 0; mGood = 0; mInRange = 1'b0; mLock = 1'b0; mFail = 1'b0; mEverLock = 1'b0;
    spuriousValid = 0;
    repeat (W + 20) begin
      @(negedge clk);
      if (countValid === 1'b1) spuriousValid++;
    end
    testsRun++;
    if (spuriousValid != 0 || edgeCount !== '0 || lock !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL postreset_idle: got pulses=%0d count=%0d lock=%b, want 0 0 0", spuriousValid, edgeCount, lock);
    end
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      spuriousValid = 0;
      driveWindow(cnts[k], 0, 1, W - 1);
      @(negedge clk);
      modelWindow(cnts[k]);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || edgeCount !== CNT_W'(mCount) || inRange !== mInRange || lock !== mLock || failFlag !== mFail) begin
        testsFailed++;
        $display("[TB] FAIL relock_w%0d: got early=%0d valid=%b count=%0d inRange=%b lock=%b fail=%b, want early=0 valid=1 count=%0d inRange=%b lock=%b fail=%b", k, spuriousValid, countValid, edgeCount, inRange, lock, failFlag, mCount, mInRange, mLock, mFail);
      end
    end
  endtask

`ifdef OSC_FREQ_MONITOR_IRQ_EN
  task automatic test_irq();
    testsRun++;
    if (irq !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL irq_on_fail: got irq=%b, want 1", irq);
    end
    irqClr = 1'b1;
    @(negedge clk);
    irqClr = 1'b0;
    testsRun++;
    if (irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL irq_clear: got irq=%b, want 0", irq);
    end
    for (int k = 0; k < 5; k++) begin
      spuriousValid = 0;
      driveWindow((k < 4) ? 200 : 100, 0, (k == 0) ? 2 : 1, W - 1);
      if (k == 4) irqClr = 1'b1;
      @(negedge clk);
      irqClr = 1'b0;
      modelWindow((k < 4) ? 200 : 100);
      testsRun++;
      if (spuriousValid != 0 || countValid !== 1'b1 || lock !== mLock || failFlag !== mFail || irq !== (k == 4)) begin
        testsFailed++;
        $display("[TB] FAIL irq_w%0d: got early=%0d valid=%b lock=%b fail=%b irq=%b, want 0 1 %b %b %b", k, spuriousValid, countValid, lock, failFlag, irq, mLock, mFail, (k == 4));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_stuck();
    test_boundary();
    test_random();
    test_enable_abort();
    test_async_reset();
`ifdef OSC_FREQ_MONITOR_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
